// File: rtl/canvas_pkg.sv
// Shared opcode constants and decoder state encoding for the canvas command path.
package canvas_pkg;

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_SET_X     = 8'h01;
   localparam logic [7:0] OP_SET_Y     = 8'h02;
   localparam logic [7:0] OP_SET_COLOR = 8'h03;
   localparam logic [7:0] OP_PLOT      = 8'h04;
   localparam logic [7:0] OP_HLINE     = 8'h05;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OPERAND = 2'd1,
      ST_EMIT    = 2'd2,
      ST_LINE    = 2'd3
   } state_t;

endpackage

// File: rtl/canvas_cmd_decoder_if.sv
// Pixel-write request bus between the command decoder and the framebuffer.
interface canvas_cmd_decoder_if #(
   parameter int CANVAS_W   = 64,
   parameter int CANVAS_H   = 48,
   parameter int COLOR_BITS = 2
);
   localparam int XW = $clog2(CANVAS_W);
   localparam int YW = $clog2(CANVAS_H);

   logic                  wr_valid;
   logic                  wr_ready;
   logic [XW-1:0]         wr_x;
   logic [YW-1:0]         wr_y;
   logic [COLOR_BITS-1:0] wr_color;

   modport master (
      output wr_valid, wr_x, wr_y, wr_color,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_x, wr_y, wr_color,
      output wr_ready
   );
endinterface

// File: rtl/canvas_sync_edge.sv
// Two-flop synchroniser for the asynchronous host strobe plus rising-edge detect.
module canvas_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/canvas_cmd_decoder.sv
// Byte-serial drawing command decoder: cursor/colour registers, PLOT and HLINE pixel emission.
module canvas_cmd_decoder #(
   parameter int CANVAS_W   = 64,
   parameter int CANVAS_H   = 48,
   parameter int COLOR_BITS = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ena,
   input  logic [7:0]                  in_data,
   input  logic                        in_strobe,
   canvas_cmd_decoder_if.master        wr_bus,
   output logic                        busy,
   output logic                        ack,
   output logic                        err
);
   import canvas_pkg::*;

   localparam int XW = $clog2(CANVAS_W);
   localparam int YW = $clog2(CANVAS_H);

   state_t                state_q, state_d;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic [COLOR_BITS-1:0] color_q, color_d;
   logic [7:0]            remaining_q, remaining_d;
   logic [7:0]            opcode_q, opcode_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;

   logic strobe_rise;
   logic byte_seen;
   logic handshake;

   canvas_sync_edge u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (in_strobe),
      .rise     (strobe_rise)
   );

   assign busy      = (state_q == ST_EMIT) || (state_q == ST_LINE);
   assign byte_seen = strobe_rise && ena;
   assign handshake = busy && wr_bus.wr_ready;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      color_d     = color_q;
      remaining_d = remaining_q;
      opcode_d    = opcode_q;
      ack_d       = ack_q;
      err_d       = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (byte_seen) begin
               ack_d = ~ack_q;
               case (in_data)
                  OP_NOP: ;
                  OP_SET_X, OP_SET_Y, OP_SET_COLOR, OP_HLINE: begin
                     opcode_d = in_data;
                     state_d  = ST_OPERAND;
                  end
                  OP_PLOT: state_d = ST_EMIT;
                  default: err_d = 1'b1;
               endcase
            end
         end

         ST_OPERAND: begin
            if (byte_seen) begin
               ack_d   = ~ack_q;
               state_d = ST_IDLE;
               case (opcode_q)
                  OP_SET_X: begin
                     if (int'(in_data) >= CANVAS_W) begin
                        x_d   = XW'(CANVAS_W - 1);
                        err_d = 1'b1;
                     end else begin
                        x_d = XW'(in_data);
                     end
                  end
                  OP_SET_Y: begin
                     if (int'(in_data) >= CANVAS_H) begin
                        y_d   = YW'(CANVAS_H - 1);
                        err_d = 1'b1;
                     end else begin
                        y_d = YW'(in_data);
                     end
                  end
                  OP_SET_COLOR: color_d = in_data[COLOR_BITS-1:0];
                  OP_HLINE: begin
                     if (in_data != 8'd0) begin
                        remaining_d = in_data;
                        state_d     = ST_LINE;
                     end
                  end
                  default: ;
               endcase
            end
         end

         ST_EMIT: begin
            // Bytes arriving mid-write are lost: flag them, but do not acknowledge.
            if (byte_seen) err_d = 1'b1;
            if (handshake) state_d = ST_IDLE;
         end

         ST_LINE: begin
            if (byte_seen) err_d = 1'b1;
            if (handshake) begin
               x_d         = (x_q == XW'(CANVAS_W - 1)) ? '0 : x_q + XW'(1);
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         color_q     <= '0;
         remaining_q <= '0;
         opcode_q    <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         color_q     <= color_d;
         remaining_q <= remaining_d;
         opcode_q    <= opcode_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
      end
   end

   // Payload comes straight from the cursor registers, so it cannot move while a write stalls.
   assign wr_bus.wr_valid = busy;
   assign wr_bus.wr_x     = x_q;
   assign wr_bus.wr_y     = y_q;
   assign wr_bus.wr_color = color_q;
   assign ack             = ack_q;
   assign err             = err_q;
endmodule

// File: tb/tb_canvas_cmd_decoder.sv
// Directed self-checking bench for canvas_cmd_decoder.
module tb_canvas_cmd_decoder;
   localparam int CANVAS_W   = 64;
   localparam int CANVAS_H   = 48;
   localparam int COLOR_BITS = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_strobe = 1'b0;
   logic       busy, ack, err;

   int n_checks = 0;
   int n_fail   = 0;

   int n_writes = 0;
   int busy_cycles = 0;
   int wx [16];
   int wy [16];
   int wc [16];

   canvas_cmd_decoder_if #(
      .CANVAS_W   (CANVAS_W),
      .CANVAS_H   (CANVAS_H),
      .COLOR_BITS (COLOR_BITS)
   ) wr_bus ();

   canvas_cmd_decoder #(
      .CANVAS_W   (CANVAS_W),
      .CANVAS_H   (CANVAS_H),
      .COLOR_BITS (COLOR_BITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_data   (in_data),
      .in_strobe (in_strobe),
      .wr_bus    (wr_bus),
      .busy      (busy),
      .ack       (ack),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge, so the falling edge sees settled values
   // that the next rising edge will act on.
   always @(negedge clk) begin
      if (busy) busy_cycles++;
      if (wr_bus.wr_valid && wr_bus.wr_ready) begin
         if (n_writes < 16) begin
            wx[n_writes] = int'(wr_bus.wr_x);
            wy[n_writes] = int'(wr_bus.wr_y);
            wc[n_writes] = int'(wr_bus.wr_color);
         end
         n_writes++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_data   = b;
      in_strobe = 1'b1;
      tick(5);
      in_strobe = 1'b0;
      tick(4);
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      wr_bus.wr_ready = 1'b1;
      tick(2);

      // Reset values
      check("rst_valid", int'(wr_bus.wr_valid), 0);
      check("rst_busy",  int'(busy), 0);
      check("rst_ack",   int'(ack), 0);
      check("rst_err",   int'(err), 0);
      check("rst_x",     int'(wr_bus.wr_x), 0);
      check("rst_y",     int'(wr_bus.wr_y), 0);
      check("rst_color", int'(wr_bus.wr_color), 0);
      rst_n = 1'b1;
      tick(2);

      // Single PLOT at (10,5) colour 3; seven accepted bytes leave ack at 1
      n_writes = 0;
      send_byte(8'h01); send_byte(8'd10);
      send_byte(8'h02); send_byte(8'd5);
      send_byte(8'h03); send_byte(8'h03);
      send_byte(8'h04);
      tick(3);
      check("plot_nwr",   n_writes, 1);
      check("plot_x",     wx[0], 10);
      check("plot_y",     wy[0], 5);
      check("plot_color", wc[0], 3);
      check("plot_ack",   int'(ack), 1);
      check("plot_err",   int'(err), 0);

      // HLINE 4 from x=62 wraps through the right edge
      n_writes = 0;
      send_byte(8'h01); send_byte(8'd62);
      send_byte(8'h05);
      busy_cycles = 0;
      send_byte(8'd4);
      tick(3);
      check("hl_nwr",  n_writes, 4);
      check("hl_x0",   wx[0], 62);
      check("hl_x1",   wx[1], 63);
      check("hl_x2",   wx[2], 0);
      check("hl_x3",   wx[3], 1);
      check("hl_y3",   wy[3], 5);
      check("hl_busy", busy_cycles, 4);
      check("hl_endx", int'(wr_bus.wr_x), 2);
      check("hl_ack",  int'(ack), 1);
      check("hl_err",  int'(err), 0);

      // PLOT with the framebuffer stalled: payload must hold
      wr_bus.wr_ready = 1'b0;
      n_writes = 0;
      send_byte(8'h04);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", int'(wr_bus.wr_valid), 1);
         check("stall_x",     int'(wr_bus.wr_x), 2);
         check("stall_y",     int'(wr_bus.wr_y), 5);
         tick(1);
      end
      check("stall_nwr0", n_writes, 0);
      wr_bus.wr_ready = 1'b1;
      tick(3);
      check("stall_nwr1",  n_writes, 1);
      check("stall_wx",    wx[0], 2);
      check("stall_idle",  int'(wr_bus.wr_valid), 0);
      check("stall_ack",   int'(ack), 0);

      // Strobes ignored while disabled
      ena = 1'b0;
      n_writes = 0;
      send_byte(8'h04);
      tick(3);
      check("ena_nwr", n_writes, 0);
      check("ena_ack", int'(ack), 0);
      ena = 1'b1;

      // SET_X 200 saturates to 63 and flags an error
      send_byte(8'h01); send_byte(8'd200);
      check("satx_x",   int'(wr_bus.wr_x), 63);
      check("satx_err", int'(err), 1);
      check("satx_ack", int'(ack), 0);

      // SET_Y 47 is in range; SET_Y 48 saturates
      send_byte(8'h02); send_byte(8'd47);
      check("sety_47", int'(wr_bus.wr_y), 47);
      send_byte(8'h02); send_byte(8'd48);
      check("sety_sat", int'(wr_bus.wr_y), 47);

      // Unknown opcode after a fresh reset
      do_reset();
      check("rst2_err", int'(err), 0);
      check("rst2_x",   int'(wr_bus.wr_x), 0);
      n_writes = 0;
      send_byte(8'h7F);
      tick(3);
      check("unk_err", int'(err), 1);
      check("unk_ack", int'(ack), 1);
      check("unk_nwr", n_writes, 0);

      // Byte arriving during a stalled HLINE 8 is dropped
      do_reset();
      wr_bus.wr_ready = 1'b0;
      n_writes = 0;
      send_byte(8'h05); send_byte(8'd8);
      check("drop_busy0", int'(busy), 1);
      check("drop_err0",  int'(err), 0);
      check("drop_ack0",  int'(ack), 0);
      send_byte(8'h00);
      check("drop_err1",  int'(err), 1);
      check("drop_ack1",  int'(ack), 0);
      check("drop_nwr",   n_writes, 0);

      // Reset after three line writes abandons the rest
      wr_bus.wr_ready = 1'b1;
      tick(3);
      check("mid_nwr",  n_writes, 3);
      check("mid_x",    int'(wr_bus.wr_x), 3);
      rst_n = 1'b0;
      #1;
      check("mid_valid", int'(wr_bus.wr_valid), 0);
      check("mid_busy",  int'(busy), 0);
      check("mid_x0",    int'(wr_bus.wr_x), 0);
      check("mid_err",   int'(err), 0);
      check("mid_ack",   int'(ack), 0);
      tick(3);
      rst_n = 1'b1;
      tick(20);
      check("post_nwr",   n_writes, 3);
      check("post_valid", int'(wr_bus.wr_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
